// File: rtl/inv_delay_pkg.sv
// Shared encodings, widths and the delay-clamp helper for inv_delay_line.
package inv_delay_pkg;

  typedef enum logic {
    INV_MODE_PASS = 1'b0,
    INV_MODE_INV  = 1'b1
  } inv_mode_e;

  localparam int TOGGLE_CNT_W = 16;

  // Select 0 means "shortest", anything past the last stage means "longest".
  function automatic int unsigned clamp_dly(input int unsigned sel, input int unsigned max_dly);
    if (sel == 0) begin
      return 1;
    end else if (sel > max_dly) begin
      return max_dly;
    end else begin
      return sel;
    end
  endfunction

endpackage

// File: rtl/inv_delay_stage.sv
// One pipeline stage: data and valid registers, async reset, sync flush.
module inv_delay_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (flush) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/inv_delay_line.sv
// Optionally inverting delay line with runtime-selectable tap.
// Build option INV_DELAY_LINE_TOGGLE_CNT_EN adds the toggle_cnt output.
module inv_delay_line
  import inv_delay_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_DLY = 4,
  localparam int DLY_W  = $clog2(MAX_DLY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             inv_mode,
  input  logic [DLY_W-1:0] dly_sel,
  input  logic             flush,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             busy
`ifdef INV_DELAY_LINE_TOGGLE_CNT_EN
  , output logic [TOGGLE_CNT_W-1:0] toggle_cnt
`endif
);

  // Valid semantics: there is no backpressure. in_valid marks a sample at the
  // edge it is captured; y_valid marks y in the cycle y is presented. Data
  // moves every cycle whether or not it is valid.

  logic [WIDTH-1:0] chain_d [MAX_DLY+1];
  logic [MAX_DLY:0] chain_v;
  logic [DLY_W-1:0] d_eff;

  // Inversion is applied before stage 0 so the mode travels with the sample.
  assign chain_d[0] = (inv_mode == INV_MODE_INV) ? ~in : in;
  assign chain_v[0] = in_valid;

  for (genvar g = 0; g < MAX_DLY; g++) begin : g_stage
    inv_delay_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .d       (chain_d[g]),
      .d_valid (chain_v[g]),
      .q       (chain_d[g+1]),
      .q_valid (chain_v[g+1])
    );
  end

  assign d_eff = DLY_W'(clamp_dly(32'(dly_sel), MAX_DLY));

  always_comb begin
    y       = '0;
    y_valid = 1'b0;
    for (int k = 0; k < MAX_DLY; k++) begin
      if (d_eff == DLY_W'(k + 1)) begin
        y       = chain_d[k+1];
        y_valid = chain_v[k+1];
      end
    end
  end

  assign busy = |chain_v[MAX_DLY:1];

`ifdef INV_DELAY_LINE_TOGGLE_CNT_EN
  logic [WIDTH-1:0] last_y;
  logic             have_last;

  // have_last keeps the first valid output after rst/flush from counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_cnt <= '0;
      last_y     <= '0;
      have_last  <= 1'b0;
    end else if (flush) begin
      toggle_cnt <= '0;
      last_y     <= '0;
      have_last  <= 1'b0;
    end else if (y_valid) begin
      last_y    <= y;
      have_last <= 1'b1;
      if (have_last && (y != last_y) && (toggle_cnt != '1)) begin
        toggle_cnt <= toggle_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inv_delay_line.sv
// Directed bench for inv_delay_line: vector table plus reset/flush/toggle sequences.
module tb_inv_delay_line;

  localparam int WIDTH   = 8;
  localparam int MAX_DLY = 4;
  localparam int DLY_W   = $clog2(MAX_DLY + 1);
  localparam int NVEC    = 33;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             inv_mode;
  logic [DLY_W-1:0] dly_sel;
  logic             flush;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             busy;
`ifdef INV_DELAY_LINE_TOGGLE_CNT_EN
  logic [15:0]      toggle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  inv_delay_line #(
    .WIDTH   (WIDTH),
    .MAX_DLY (MAX_DLY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .in_valid   (in_valid),
    .inv_mode   (inv_mode),
    .dly_sel    (dly_sel),
    .flush      (flush),
    .y          (y),
    .y_valid    (y_valid),
    .busy       (busy)
`ifdef INV_DELAY_LINE_TOGGLE_CNT_EN
    , .toggle_cnt (toggle_cnt)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             inv_mode;
    logic [DLY_W-1:0] dly_sel;
    logic             flush;
    logic [WIDTH-1:0] exp_y;
    logic             exp_y_valid;
    logic             exp_busy;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [WIDTH-1:0] i, input logic iv, input logic im,
                              input logic [DLY_W-1:0] ds, input logic fl,
                              input logic [WIDTH-1:0] ey, input logic eyv, input logic eb);
    vec_t v;
    v.in = i; v.in_valid = iv; v.inv_mode = im; v.dly_sel = ds; v.flush = fl;
    v.exp_y = ey; v.exp_y_valid = eyv; v.exp_busy = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] i, input logic iv, input logic im,
                       input logic [DLY_W-1:0] ds, input logic fl);
    in = i; in_valid = iv; inv_mode = im; dly_sel = ds; flush = fl;
  endtask

  // advance one edge; inputs change 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [WIDTH-1:0] ey, input logic eyv,
                           input logic eb);
    check({name, " y"}, 32'(y), 32'(ey));
    check({name, " y_valid"}, 32'(y_valid), 32'(eyv));
    check({name, " busy"}, 32'(busy), 32'(eb));
  endtask

  initial begin
    // {in, in_valid, inv_mode, dly_sel, flush} -> outputs seen in that same cycle
    vecs[0]  = mk(8'hA5, 1, 1, 3'd3, 0, 8'h00, 0, 0);
    vecs[1]  = mk(8'h00, 0, 0, 3'd3, 0, 8'h00, 0, 1);
    vecs[2]  = mk(8'h00, 0, 0, 3'd3, 0, 8'h00, 0, 1);
    vecs[3]  = mk(8'h00, 0, 0, 3'd3, 0, 8'h5A, 1, 1);
    vecs[4]  = mk(8'h00, 0, 0, 3'd3, 0, 8'h00, 0, 1);
    vecs[5]  = mk(8'h00, 0, 0, 3'd3, 0, 8'h00, 0, 0);
    vecs[6]  = mk(8'h3C, 1, 0, 3'd0, 0, 8'h00, 0, 0);
    vecs[7]  = mk(8'h00, 0, 0, 3'd0, 0, 8'h3C, 1, 1);
    vecs[8]  = mk(8'h00, 0, 0, 3'd0, 0, 8'h00, 0, 1);
    vecs[9]  = mk(8'h00, 0, 0, 3'd7, 0, 8'h00, 0, 1);
    vecs[10] = mk(8'h00, 0, 0, 3'd7, 0, 8'h3C, 1, 1);
    vecs[11] = mk(8'h00, 0, 0, 3'd7, 0, 8'h00, 0, 0);
    vecs[12] = mk(8'h96, 1, 0, 3'd7, 0, 8'h00, 0, 0);
    vecs[13] = mk(8'h00, 0, 0, 3'd7, 0, 8'h00, 0, 1);
    vecs[14] = mk(8'h00, 0, 0, 3'd7, 0, 8'h00, 0, 1);
    vecs[15] = mk(8'h00, 0, 0, 3'd7, 0, 8'h00, 0, 1);
    vecs[16] = mk(8'h00, 0, 0, 3'd7, 0, 8'h96, 1, 1);
    vecs[17] = mk(8'h00, 0, 0, 3'd7, 0, 8'h00, 0, 0);
    vecs[18] = mk(8'h01, 1, 0, 3'd2, 0, 8'h00, 0, 0);
    vecs[19] = mk(8'h02, 1, 0, 3'd2, 0, 8'h00, 0, 1);
    vecs[20] = mk(8'h03, 1, 0, 3'd2, 0, 8'h01, 1, 1);
    vecs[21] = mk(8'h04, 1, 0, 3'd2, 0, 8'h02, 1, 1);
    vecs[22] = mk(8'h05, 1, 0, 3'd2, 1, 8'h03, 1, 1);
    vecs[23] = mk(8'h00, 0, 0, 3'd2, 0, 8'h00, 0, 0);
    vecs[24] = mk(8'h00, 0, 0, 3'd4, 0, 8'h00, 0, 0);
    vecs[25] = mk(8'h00, 0, 0, 3'd4, 0, 8'h00, 0, 0);
    vecs[26] = mk(8'hFF, 1, 0, 3'd1, 0, 8'h00, 0, 0);
    vecs[27] = mk(8'hFF, 1, 1, 3'd1, 0, 8'hFF, 1, 1);
    vecs[28] = mk(8'h00, 0, 0, 3'd1, 0, 8'h00, 1, 1);
    vecs[29] = mk(8'h00, 0, 0, 3'd1, 0, 8'h00, 0, 1);
    vecs[30] = mk(8'h00, 0, 0, 3'd1, 0, 8'h00, 0, 1);
    vecs[31] = mk(8'h00, 0, 0, 3'd1, 0, 8'h00, 0, 1);
    vecs[32] = mk(8'h00, 0, 0, 3'd1, 0, 8'h00, 0, 0);

    rst = 1'b1;
    drive(8'h00, 0, 0, 3'd1, 0);
    #1;
    check_out("reset", 8'h00, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].in, vecs[i].in_valid, vecs[i].inv_mode, vecs[i].dly_sel, vecs[i].flush);
      @(negedge clk);
      check_out($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_y_valid, vecs[i].exp_busy);
      tick();
    end

    // async reset mid-stream, sample during reset lost, capture resumes
    drive(8'h11, 1, 0, 3'd1, 0);
    tick();
    drive(8'h00, 0, 0, 3'd1, 0);
    @(negedge clk);
    check_out("pre_rst", 8'h11, 1, 1);
    #2;
    rst = 1'b1;
    drive(8'h22, 1, 0, 3'd1, 0);
    #1;
    check_out("async_rst", 8'h00, 0, 0);
    tick();
    rst = 1'b0;
    drive(8'h00, 0, 0, 3'd1, 0);
    @(negedge clk);
    check_out("rst_lost", 8'h00, 0, 0);
    tick();
    drive(8'h33, 1, 0, 3'd1, 0);
    tick();
    drive(8'h00, 0, 0, 3'd1, 0);
    @(negedge clk);
    check_out("resume", 8'h33, 1, 1);
    tick();

`ifdef INV_DELAY_LINE_TOGGLE_CNT_EN
    drive(8'h00, 0, 0, 3'd1, 1);
    tick();
    @(negedge clk);
    check("tcnt_flush", 32'(toggle_cnt), 32'd0);
    tick();
    drive(8'h00, 1, 0, 3'd1, 0); tick();
    drive(8'h00, 1, 0, 3'd1, 0); tick();
    drive(8'hFF, 1, 0, 3'd1, 0); tick();
    drive(8'h00, 1, 0, 3'd1, 0); tick();
    drive(8'h00, 0, 0, 3'd1, 0); tick();
    tick();
    @(negedge clk);
    check("tcnt_two", 32'(toggle_cnt), 32'd2);
    tick();
    for (int i = 0; i < 70000; i++) begin
      drive((i % 2 == 1) ? 8'hFF : 8'h00, 1, 0, 3'd1, 0);
      tick();
    end
    drive(8'h00, 0, 0, 3'd1, 0);
    tick();
    tick();
    @(negedge clk);
    check("tcnt_sat", 32'(toggle_cnt), 32'h0000FFFF);
    tick();
    drive(8'h00, 0, 0, 3'd1, 1);
    tick();
    drive(8'h00, 0, 0, 3'd1, 0);
    @(negedge clk);
    check("tcnt_clear", 32'(toggle_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
